// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, N_BIT data bits LSB first, even parity, stop bit.
// Counts s_tick pulses to sample each bit at its midpoint.
module uart_rx #(
  parameter int N_BIT   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tick,
  input  logic             rx,
  output logic [N_BIT-1:0] dout,
  output logic             rx_done_tick,
  output logic             parity_err,
  output logic             frame_err,
  output logic             rx_busy
);

  localparam int BW = (N_BIT > 1) ? $clog2(N_BIT) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(N_BIT - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [3:0]    MID_TICK  = 4'(SB_TICK / 2 - 1);
  localparam logic [3:0]    LAST_TICK = 4'(SB_TICK - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [3:0]       tick_count;
  logic [BW-1:0]    bit_count;
  logic [N_BIT-1:0] shreg;
  logic             parity_s;
  logic             rx_meta, rx_s, rx_prev;

  // Two-flop synchronizer plus one extra stage for falling-edge detection;
  // all reset to the idle-high line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_count   <= '0;
      bit_count    <= '0;
      shreg        <= '0;
      parity_s     <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking default here; the later assignment in STOP wins, giving a one-clk pulse.
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state      <= START;
            tick_count <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_count == MID_TICK) begin
              if (!rx_s) begin
                state      <= DATA;
                tick_count <= '0;
                bit_count  <= '0;
              end else begin
                state <= IDLE;  // line went back high before mid-bit: glitch
              end
            end else begin
              tick_count <= tick_count + 4'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_count == LAST_TICK) begin
              shreg      <= {rx_s, shreg[N_BIT-1:1]};
              tick_count <= '0;
              if (bit_count == LAST_BIT) state <= PARITY;
              else                       bit_count <= bit_count + BIT_ONE;
            end else begin
              tick_count <= tick_count + 4'd1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (tick_count == LAST_TICK) begin
              parity_s   <= rx_s;
              tick_count <= '0;
              state      <= STOP;
            end else begin
              tick_count <= tick_count + 4'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (tick_count == LAST_TICK) begin
              dout         <= shreg;
              parity_err   <= parity_s ^ (^shreg);
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
              tick_count   <= '0;
              state        <= IDLE;
            end else begin
              tick_count <= tick_count + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

endmodule
